// File: rtl/frame_commit_ctrl.sv
// rtl/frame_commit_ctrl.sv - raster timing generator with vertical-blank commit-window arbiter
module frame_commit_ctrl #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int COMMIT_MAX = 64
) (
    input  logic        pclk,
    input  logic        rstn,
    input  logic        en,
    input  logic        req1,
    input  logic        req2,
    input  logic        done1,
    input  logic        done2,
    output logic        hen,
    output logic        ven,
    output logic        hsync,
    output logic        vsync,
    output logic [10:0] hcnt,
    output logic [9:0]  vcnt,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        commit_open,
    output logic        gnt1,
    output logic        gnt2,
    output logic        timeout
);
    localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_TOTAL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam int          GW       = $clog2(COMMIT_MAX + 1);
    localparam logic [GW-1:0] G_MAX  = GW'(COMMIT_MAX);
    localparam logic [GW-1:0] G_ONE  = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G1   = 2'd1,
        S_G2   = 2'd2
    } state_t;

    logic [10:0]   r_h;
    logic [9:0]    r_v;
    logic [7:0]    r_fc;
    logic [10:0]   r_hcnt;
    logic [9:0]    r_vcnt;
    logic [7:0]    r_fcnt;
    logic          r_hen;
    logic          r_ven;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_fs;
    logic          r_open;
    state_t        r_state;
    logic          r_rr;
    logic [GW-1:0] r_gcnt;
    logic          r_gnt1;
    logic          r_gnt2;
    logic          r_timeout;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_limit;
    state_t        w_state_nxt;
    logic          w_rr_nxt;
    logic [GW-1:0] w_gcnt_nxt;
    logic          w_to_nxt;

    assign w_h_last = (r_h == H_TOTAL - 11'd1);
    assign w_v_last = (r_v == V_TOTAL - 10'd1);
    assign w_limit  = (r_gcnt == G_MAX);

    // Free-running raster position and frame number; frozen while en is low
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_h  <= '0;
            r_v  <= '0;
            r_fc <= '0;
        end else if (en) begin
            if (w_h_last) begin
                r_h <= '0;
                if (w_v_last) begin
                    r_v  <= '0;
                    r_fc <= r_fc + 8'd1;
                end else begin
                    r_v <= r_v + 10'd1;
                end
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    // Registered decodes so every painter-facing output describes the same pixel
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_fcnt  <= '0;
            r_hen   <= 1'b0;
            r_ven   <= 1'b0;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
            r_fs    <= 1'b0;
            r_open  <= 1'b0;
        end else begin
            r_hcnt  <= r_h;
            r_vcnt  <= r_v;
            r_fcnt  <= r_fc;
            r_hen   <= (r_h < H_ACT) && en;
            r_ven   <= (r_v < V_ACT) && en;
            r_hsync <= ((r_h >= HS_START) && (r_h < HS_END)) ? HS_POL : ~HS_POL;
            r_vsync <= ((r_v >= VS_START) && (r_v < VS_END)) ? VS_POL : ~VS_POL;
            r_fs    <= (r_h == 11'd0) && (r_v == 10'd0) && en;
            // Last blanking line is a guard line: window shuts one line early
            r_open  <= !en || ((r_v >= V_ACT) && (r_v < V_TOTAL - 10'd1));
        end
    end

    // Arbiter next state: round-robin grant, released by done, revoked by limit or window close
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_gcnt_nxt  = r_gcnt;
        w_to_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_open && req1 && (!r_rr || !req2)) begin
                    w_state_nxt = S_G1;
                    w_gcnt_nxt  = G_ONE;
                end else if (r_open && req2 && (r_rr || !req1)) begin
                    w_state_nxt = S_G2;
                    w_gcnt_nxt  = G_ONE;
                end
            end
            S_G1: begin
                if (done1) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = 1'b1;
                end else if (w_limit || !r_open) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = 1'b1;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_gcnt_nxt = r_gcnt + G_ONE;
                end
            end
            S_G2: begin
                if (done2) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = 1'b0;
                end else if (w_limit || !r_open) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = 1'b0;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_gcnt_nxt = r_gcnt + G_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Arbiter state, pointer, grant counter and registered grant/timeout outputs
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_rr      <= 1'b0;
            r_gcnt    <= '0;
            r_gnt1    <= 1'b0;
            r_gnt2    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_gnt1    <= (w_state_nxt == S_G1);
            r_gnt2    <= (w_state_nxt == S_G2);
            r_timeout <= w_to_nxt;
        end
    end

    assign hen         = r_hen;
    assign ven         = r_ven;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hcnt        = r_hcnt;
    assign vcnt        = r_vcnt;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fcnt;
    assign commit_open = r_open;
    assign gnt1        = r_gnt1;
    assign gnt2        = r_gnt2;
    assign timeout     = r_timeout;

endmodule
